// File: rtl/bit_width_expander_mod_pkg.sv
// bit_width_expander_mod_pkg: shared lane-packing constants and helpers for the width expander/reducer pair
package bit_width_expander_mod_pkg;
    localparam int MAX_WIDTH = 1024;
    localparam logic [MAX_WIDTH-1:0] IDLE_PATTERN = '1;

    function automatic int clogb2(input int v);
        int n = 0;
        for (int x = v; x > 0; x = x >> 1) n++;
        return n < 1 ? 1 : n;
    endfunction

    function automatic int bit_ratio(input int dout_width, input int din_width);
        return dout_width / din_width;
    endfunction

    function automatic int lane_cnt_width(input int ratio);
        return clogb2(ratio - 1);
    endfunction

    // lane i occupies [w*i +: w]; lane 0 is the first word on the narrow side
    function automatic int lane_lsb(input int lane, input int w);
        return lane * w;
    endfunction
endpackage

// File: rtl/bit_width_expander_mod_out_reg.sv
// expander_out_reg: single-entry valid/ready holding register for a data word and its keep mask
module expander_out_reg
    import bit_width_expander_mod_pkg::*;
#(
    parameter int DW = 128,
    parameter int KW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic [KW-1:0] load_keep,
    input  logic          ready,
    output logic [DW-1:0] data,
    output logic [KW-1:0] keep,
    output logic          valid
);
    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= IDLE_PATTERN[DW-1:0];
            keep  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            keep  <= load_keep;
            valid <= 1'b1;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/bit_width_expander_mod.sv
// bit_width_expander_mod: packs BIT_RATIO narrow words into one wide word, early close pads with all-ones
module bit_width_expander_mod
    import bit_width_expander_mod_pkg::*;
#(
    parameter int DIN_WIDTH  = 64,
    parameter int DOUT_WIDTH = 128
) (
    input  logic                                  CLK,
    input  logic                                  RESET,
    input  logic [DIN_WIDTH-1:0]                  DIN,
    input  logic                                  DIN_VALID,
    input  logic                                  DIN_LAST,
    output logic                                  DIN_READY,
    output logic [DOUT_WIDTH-1:0]                 DOUT,
    output logic [DOUT_WIDTH/DIN_WIDTH-1:0]       DOUT_KEEP,
    output logic                                  DOUT_VALID,
    input  logic                                  DOUT_READY,
    output logic                                  PACK_ACTIVE
);
    localparam int BIT_RATIO = bit_ratio(DOUT_WIDTH, DIN_WIDTH);
    localparam int LANE_CNT_WIDTH = lane_cnt_width(BIT_RATIO);
    localparam logic [DOUT_WIDTH-1:0] IDLE = IDLE_PATTERN[DOUT_WIDTH-1:0];
    localparam logic [LANE_CNT_WIDTH:0] LAST_LANE = (LANE_CNT_WIDTH+1)'(BIT_RATIO - 1);
    localparam logic [LANE_CNT_WIDTH:0] ONE = (LANE_CNT_WIDTH+1)'(1);

    if ((DOUT_WIDTH % DIN_WIDTH) != 0 || BIT_RATIO < 2) begin : g_bad_params
        $error("bit_width_expander_mod: DOUT_WIDTH must be an integer multiple (>=2) of DIN_WIDTH");
    end

    logic [LANE_CNT_WIDTH:0] lane_count;
    logic [DOUT_WIDTH-1:0]   asm_data, merged_data;
    logic [BIT_RATIO-1:0]    asm_keep, merged_keep;
    logic                    in_fire, close;

    // ready is deliberately combinational from DOUT_READY so a full word can drain and refill in one cycle
    assign DIN_READY   = ~DOUT_VALID | DOUT_READY;
    assign in_fire     = DIN_VALID & DIN_READY;
    assign close       = in_fire & (DIN_LAST | (lane_count == LAST_LANE));
    assign PACK_ACTIVE = lane_count != '0;

    for (genvar i = 0; i < BIT_RATIO; i++) begin : g_lane
        logic sel;
        assign sel = lane_count == (LANE_CNT_WIDTH+1)'(i);
        assign merged_data[lane_lsb(i, DIN_WIDTH) +: DIN_WIDTH] =
            sel ? DIN : asm_data[lane_lsb(i, DIN_WIDTH) +: DIN_WIDTH];
        assign merged_keep[i] = asm_keep[i] | sel;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            lane_count <= '0;
            asm_data   <= IDLE;
            asm_keep   <= '0;
        end else if (in_fire) begin
            lane_count <= close ? '0 : lane_count + ONE;
            asm_data   <= close ? IDLE : merged_data;
            asm_keep   <= close ? '0 : merged_keep;
        end
    end

    expander_out_reg #(
        .DW(DOUT_WIDTH),
        .KW(BIT_RATIO)
    ) u_out_reg (
        .clk      (CLK),
        .rst      (RESET),
        .load     (close),
        .load_data(merged_data),
        .load_keep(merged_keep),
        .ready    (DOUT_READY),
        .data     (DOUT),
        .keep     (DOUT_KEEP),
        .valid    (DOUT_VALID)
    );
endmodule

// File: tb/tb_bit_width_expander_mod.sv
// tb_bit_width_expander_mod: directed scoreboard bench for the 2:1 expander plus a 4:1 build
module tb_bit_width_expander_mod;
    typedef struct {
        logic [127:0] d;
        logic [1:0]   k;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  din;
    logic         din_valid, din_last, din_ready;
    logic [127:0] dout;
    logic [1:0]   dout_keep;
    logic         dout_valid, dout_ready, pack_active;

    logic [31:0]  b_din;
    logic         b_din_valid, b_din_last, b_din_ready;
    logic [127:0] b_dout;
    logic [3:0]   b_dout_keep;
    logic         b_dout_valid, b_dout_ready, b_pack_active;

    int   passed = 0;
    int   total = 0;
    exp_t q[$];

    localparam logic [63:0]  ONES64 = '1;
    localparam logic [127:0] ONES128 = '1;

    always #5 clk = ~clk;

    bit_width_expander_mod dut (
        .CLK(clk), .RESET(rst), .DIN(din), .DIN_VALID(din_valid), .DIN_LAST(din_last),
        .DIN_READY(din_ready), .DOUT(dout), .DOUT_KEEP(dout_keep), .DOUT_VALID(dout_valid),
        .DOUT_READY(dout_ready), .PACK_ACTIVE(pack_active)
    );

    bit_width_expander_mod #(.DIN_WIDTH(32), .DOUT_WIDTH(128)) dut4 (
        .CLK(clk), .RESET(rst), .DIN(b_din), .DIN_VALID(b_din_valid), .DIN_LAST(b_din_last),
        .DIN_READY(b_din_ready), .DOUT(b_dout), .DOUT_KEEP(b_dout_keep), .DOUT_VALID(b_dout_valid),
        .DOUT_READY(b_dout_ready), .PACK_ACTIVE(b_pack_active)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] d, input logic v, input logic l, input logic r);
        din = d;
        din_valid = v;
        din_last = l;
        dout_ready = r;
    endtask

    task automatic push(input logic [127:0] d, input logic [1:0] k);
        q.push_back('{d: d, k: k});
    endtask

    task automatic bdrive(input logic [31:0] d, input logic v, input logic l);
        b_din = d;
        b_din_valid = v;
        b_din_last = l;
    endtask

    // outputs are compared against the scoreboard on the negedge before each accepting edge
    always @(negedge clk) begin
        if (!rst && dout_valid && dout_ready) begin
            chk("sb_pending", 128'(q.size() != 0), 128'd1);
            if (q.size() != 0) begin
                chk("sb_dout", dout, q[0].d);
                chk("sb_keep", 128'(dout_keep), 128'(q[0].k));
                void'(q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive(64'h0, 1'b0, 1'b0, 1'b0);
        bdrive(32'h0, 1'b0, 1'b0);
        b_dout_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_dout", dout, ONES128);
        chk("rst_keep", 128'(dout_keep), 128'd0);
        chk("rst_valid", 128'(dout_valid), 128'd0);
        chk("rst_din_ready", 128'(din_ready), 128'd1);
        chk("rst_pack", 128'(pack_active), 128'd0);

        drive(64'hA0, 1'b1, 1'b0, 1'b1);
        tick();
        chk("full_pack", 128'(pack_active), 128'd1);
        chk("full_no_valid", 128'(dout_valid), 128'd0);
        drive(64'hA1, 1'b1, 1'b0, 1'b1);
        push({64'hA1, 64'hA0}, 2'b11);
        tick();
        chk("full_a_valid", 128'(dout_valid), 128'd1);
        drive(64'hB0, 1'b1, 1'b0, 1'b1);
        tick();
        chk("full_a_drained", 128'(dout_valid), 128'd0);
        drive(64'hB1, 1'b1, 1'b0, 1'b1);
        push({64'hB1, 64'hB0}, 2'b11);
        tick();
        chk("full_b_valid", 128'(dout_valid), 128'd1);

        drive(64'h5, 1'b1, 1'b1, 1'b1);
        push({ONES64, 64'h5}, 2'b01);
        tick();
        chk("early_valid", 128'(dout_valid), 128'd1);
        chk("early_pack", 128'(pack_active), 128'd0);
        drive(64'h0, 1'b0, 1'b1, 1'b1);
        tick();
        chk("last_wo_valid_ignored", 128'(pack_active), 128'd0);
        chk("early_drained", 128'(dout_valid), 128'd0);

        drive(64'hD0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(64'hD1, 1'b1, 1'b0, 1'b0);
        push({64'hD1, 64'hD0}, 2'b11);
        tick();
        chk("bp_valid", 128'(dout_valid), 128'd1);
        chk("bp_din_ready", 128'(din_ready), 128'd0);
        drive(64'hE0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        chk("bp_dout_stable", dout, {64'hD1, 64'hD0});
        chk("bp_keep_stable", 128'(dout_keep), 128'd3);
        chk("bp_not_consumed", 128'(pack_active), 128'd0);
        chk("bp_still_stalled", 128'(din_ready), 128'd0);
        drive(64'hE0, 1'b1, 1'b0, 1'b1);
        tick();
        chk("bp_release_valid", 128'(dout_valid), 128'd0);
        chk("bp_release_pack", 128'(pack_active), 128'd1);
        drive(64'hE1, 1'b1, 1'b0, 1'b0);
        push({64'hE1, 64'hE0}, 2'b11);
        tick();
        drive(64'hF0, 1'b1, 1'b1, 1'b1);
        push({ONES64, 64'hF0}, 2'b01);
        tick();
        chk("b2b_valid", 128'(dout_valid), 128'd1);
        chk("b2b_dout", dout, {ONES64, 64'hF0});
        drive(64'h0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("b2b_drained", 128'(dout_valid), 128'd0);

        for (int i = 0; i < 8; i++) begin
            drive(64'h100 + 64'(i), 1'b1, 1'b0, 1'b1);
            if (i % 2 == 1) push({64'h100 + 64'(i), 64'h100 + 64'(i - 1)}, 2'b11);
            chk("stream_din_ready", 128'(din_ready), 128'd1);
            tick();
            chk("stream_valid", 128'(dout_valid), 128'(i % 2 == 1));
        end

        drive(64'h99, 1'b1, 1'b0, 1'b1);
        tick();
        chk("mid_pack", 128'(pack_active), 128'd1);
        drive(64'h0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_pack", 128'(pack_active), 128'd0);
        chk("mid_rst_valid", 128'(dout_valid), 128'd0);
        chk("mid_rst_dout", dout, ONES128);
        chk("mid_rst_din_ready", 128'(din_ready), 128'd1);
        drive(64'hC0, 1'b1, 1'b0, 1'b1);
        tick();
        drive(64'hC1, 1'b1, 1'b0, 1'b1);
        push({64'hC1, 64'hC0}, 2'b11);
        tick();
        chk("mid_c_valid", 128'(dout_valid), 128'd1);
        drive(64'h0, 1'b0, 1'b0, 1'b1);
        tick();

        bdrive(32'h11, 1'b1, 1'b0);
        tick();
        bdrive(32'h22, 1'b1, 1'b0);
        tick();
        chk("r4_pack", 128'(b_pack_active), 128'd1);
        bdrive(32'h33, 1'b1, 1'b1);
        tick();
        chk("r4_early_valid", 128'(b_dout_valid), 128'd1);
        chk("r4_early_dout", b_dout, {32'hFFFF_FFFF, 32'h33, 32'h22, 32'h11});
        chk("r4_early_keep", 128'(b_dout_keep), 128'b0111);
        chk("r4_early_pack", 128'(b_pack_active), 128'd0);
        for (int i = 1; i <= 4; i++) begin
            bdrive(32'h40 + 32'(i), 1'b1, 1'b0);
            tick();
            chk("r4_full_valid", 128'(b_dout_valid), 128'(i == 4));
        end
        chk("r4_full_dout", b_dout, {32'h44, 32'h43, 32'h42, 32'h41});
        chk("r4_full_keep", 128'(b_dout_keep), 128'b1111);
        bdrive(32'h0, 1'b0, 1'b0);
        tick();

        chk("sb_empty", 128'(q.size()), 128'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
